// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// State encoding, digit width and a digit-count helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest digit count that holds 2**width-1 without overflow
  function automatic int digits_needed(input int width);
    longint unsigned v;
    int n;
    v = (longint'(1) << width) - 1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n = n + 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bundle of the converter.
// Master drives start/bin, slave returns the BCD result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
  logic                  overflow;

  modport master (
    output start, bin,
    input  ready, done, bcd, blank, overflow
  );

  modport slave (
    input  start, bin,
    output ready, done, bcd, blank, overflow
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// One shift-and-add-3 correction cell.
// A digit of 5 or more gets +3 so the next shift carries correctly.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_d,
  output logic [BCD_DIGIT_W-1:0] o_d
);

  // 4-bit add, no carry out of the digit
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// Adds overflow flag and leading-zero blanking mask.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input logic            clk,
  input logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST =
    {DIGITS{1'b1}} ^ DIGITS'(1);

  state_t             r_state;
  logic [BIN_W-1:0]   r_sreg;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;
  logic               r_ready;
  logic               r_done;
  logic [ACC_W-1:0]   r_bcd;
  logic [DIGITS-1:0]  r_blank;
  logic               r_ovf;

  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [BIN_W-1:0]   w_sreg_nxt;
  logic               w_shout;
  logic               w_accept;
  logic [DIGITS-1:0]  w_blank;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_d (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_d (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  assign {w_shout, w_acc_nxt, w_sreg_nxt} = {w_adj, r_sreg, 1'b0};
  assign w_accept = bus.start && (r_state != SHIFT);

  // Leading-zero mask of the next accumulator; units never blanked
  always_comb begin
    logic z;
    w_blank = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z = z & (w_acc_nxt[k*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      w_blank[k] = z;
    end
  end

  // Control FSM, datapath and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_bcd    <= '0;
      r_blank  <= BLANK_RST;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_sreg   <= bus.bin;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_acc    <= w_acc_nxt;
          r_sreg   <= w_sreg_nxt;
          r_sticky <= r_sticky | w_shout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_bcd   <= w_acc_nxt;
            r_blank <= w_blank;
            r_ovf   <= r_sticky | w_shout;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.blank    = r_blank;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (4- and 5-digit instances).
// Hand-computed expectations, immediate assertions.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) b4 ();
  bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(5)) b5 ();

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(5)) u5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b5.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [13:0] v);
    b4.start = s;
    b4.bin   = v;
    b5.start = s;
    b5.bin   = v;
  endtask

  // Pulse start for one edge, then count negedges until done
  task automatic convert(input logic [13:0] v, output int n);
    @(posedge clk); #1;
    drive(1'b1, v);
    @(posedge clk); #1;
    drive(1'b0, 14'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b4.done && n < 60);
  endtask

  int n;
  int dcount;

  initial begin
    drive(1'b0, 14'd0);
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(b4.ready), 32'd1);
    chk("rst_done", 32'(b4.done), 32'd0);
    chk("rst_bcd", 32'(b4.bcd), 32'h0000);
    chk("rst_blank", 32'(b4.blank), 32'b1110);
    chk("rst_ovf", 32'(b4.overflow), 32'd0);
    chk("rst_blank5", 32'(b5.blank), 32'b11110);

    // zero
    convert(14'd0, n);
    chk("lat0", 32'(n), 32'd15);
    chk("zero_bcd", 32'(b4.bcd), 32'h0000);
    chk("zero_blank", 32'(b4.blank), 32'b1110);
    chk("zero_ovf", 32'(b4.overflow), 32'd0);
    chk("zero_ready", 32'(b4.ready), 32'd1);

    // 42
    convert(14'd42, n);
    chk("lat42", 32'(n), 32'd15);
    chk("42_bcd", 32'(b4.bcd), 32'h0042);
    chk("42_blank", 32'(b4.blank), 32'b1100);
    chk("42_ovf", 32'(b4.overflow), 32'd0);
    chk("42_blank5", 32'(b5.blank), 32'b11100);
    @(negedge clk);
    chk("done_pulse", 32'(b4.done), 32'd0);
    chk("hold_bcd", 32'(b4.bcd), 32'h0042);

    // 9999
    convert(14'd9999, n);
    chk("9999_bcd", 32'(b4.bcd), 32'h9999);
    chk("9999_blank", 32'(b4.blank), 32'b0000);
    chk("9999_ovf", 32'(b4.overflow), 32'd0);
    chk("9999_bcd5", 32'(b5.bcd), 32'h09999);
    chk("9999_blank5", 32'(b5.blank), 32'b10000);

    // max value: overflow on 4 digits, fits 5
    convert(14'd16383, n);
    chk("max_bcd", 32'(b4.bcd), 32'h6383);
    chk("max_ovf", 32'(b4.overflow), 32'd1);
    chk("max_blank", 32'(b4.blank), 32'b0000);
    chk("max_bcd5", 32'(b5.bcd), 32'h16383);
    chk("max_ovf5", 32'(b5.overflow), 32'd0);
    chk("max_blank5", 32'(b5.blank), 32'b00000);

    // start during SHIFT ignored
    @(posedge clk); #1;
    drive(1'b1, 14'd1234);
    @(posedge clk); #1;
    drive(1'b0, 14'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_ready", 32'(b4.ready), 32'd0);
    drive(1'b1, 14'd777);
    @(posedge clk); #1;
    drive(1'b0, 14'd777);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b4.done && n < 60);
    chk("ign_done", 32'(b4.done), 32'd1);
    chk("ign_lat", 32'(n), 32'd9);
    chk("ign_bcd", 32'(b4.bcd), 32'h1234);
    chk("ign_blank", 32'(b4.blank), 32'b0000);
    @(negedge clk);
    chk("ign_ready", 32'(b4.ready), 32'd1);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (b4.done) dcount++;
    end
    chk("ign_no_2nd", 32'(dcount), 32'd0);

    // back-to-back
    @(posedge clk); #1;
    drive(1'b1, 14'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b4.done && n < 60);
    chk("b2b_first", 32'(b4.bcd), 32'h0001);
    chk("b2b_first_blank", 32'(b4.blank), 32'b1110);
    drive(1'b1, 14'd2);
    @(posedge clk); #1;
    drive(1'b0, 14'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b4.done && n < 60);
    chk("b2b_gap", 32'(n), 32'd15);
    chk("b2b_second", 32'(b4.bcd), 32'h0002);

    // reset mid-conversion
    @(posedge clk); #1;
    drive(1'b1, 14'd5000);
    @(posedge clk); #1;
    drive(1'b0, 14'd0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(b4.ready), 32'd1);
    chk("abort_done", 32'(b4.done), 32'd0);
    chk("abort_bcd", 32'(b4.bcd), 32'h0000);
    chk("abort_blank", 32'(b4.blank), 32'b1110);
    chk("abort_ovf", 32'(b4.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (b4.done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    convert(14'd5000, n);
    chk("post_lat", 32'(n), 32'd15);
    chk("post_bcd", 32'(b4.bcd), 32'h5000);
    chk("post_blank", 32'(b4.blank), 32'b0000);
    chk("post_ovf", 32'(b4.overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using shift-and-add-3, one input bit per clock. It is the multi-cycle successor to the combinational score converter.
- Trades latency for area: one correction stage per digit instead of BIN_W unrolled stages.
- Adds a start/done handshake, overflow detection and a leading-zero blanking mask.
- Sits between the score/timer counters and the 7-segment and on-screen digit renderers.

Parameters:
BIN_W, 14, width of the binary input, 2..32.
DIGITS, 4, number of BCD output digits, 1..10.
CNT_W, $clog2(BIN_W), width of the iteration counter. Derived; not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request a conversion; sampled only when ready=1.
bin  in  BIN_W  unsigned binary value; captured on the accepted start edge only.
ready  out  1  high when a start will be accepted (IDLE or DONE state).
done  out  1  single-cycle pulse when bcd, blank and overflow update.
bcd  out  4*DIGITS  packed BCD result; digit 0 (units) in [3:0].
blank  out  DIGITS  bit k=1 when digit k is a leading zero; bit 0 is always 0.
overflow  out  1  bin > 10^DIGITS-1; bcd then holds bin mod 10^DIGITS.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, ready=1, done=0, bcd=0, blank={DIGITS-1{1},0}, overflow=0.
  - Internal shift register and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → capture bin into the shift register, clear the BCD accumulator, cnt=0, clear the sticky overflow bit, go to SHIFT.
- SHIFT, each edge:
  - Every accumulator digit >=5 gets +3 (4-bit, no carry between digits).
  - Then shift {acc, sreg} left by 1.
  - The bit shifted out of the accumulator MSB ORs into the sticky overflow bit.
  - cnt increments. When cnt==BIN_W-1, go to DONE and register the outputs:
    - bcd = next accumulator value.
    - overflow = sticky bit, including this cycle's shifted-out bit.
    - blank computed from the next accumulator: bit k=1 iff digits k..DIGITS-1 are all zero, for k>=1.
- DONE: done=1 for exactly this cycle, ready=1.
  - start=1 here → same action as IDLE start (back-to-back conversions allowed).
  - Otherwise go to IDLE.
- ready=0 only in SHIFT. start while in SHIFT is ignored: no queuing, and bin is not re-sampled.
- Latency: done is high in the cycle after BIN_W SHIFT edges. That is BIN_W+1 edges after the start edge; throughput is one conversion per BIN_W+1 cycles.
- Outputs bcd/blank/overflow hold their last value between done pulses. They never show partial results.
- bin may change freely after the start edge.
- Reset mid-conversion: abort immediately. Outputs return to reset values and no done pulse is produced.
- Arithmetic: all digit adjustments are 4-bit unsigned. The accumulator is exactly 4*DIGITS bits and bits above it are discarded into overflow only.

Decomposition:
- Shared package bcd_pkg:
  - State enum {IDLE, SHIFT, DONE}.
  - Function digits_needed(width), returning the minimum DIGITS for a given BIN_W.
  - Constant BCD_DIGIT_W=4.
- One natural sub-module, bcd_digit_adj: combinational 4-bit "if >=5 add 3". Instantiated DIGITS times via generate.
- Blanking and overflow logic stay in the top module.

Test Plan:
1. BIN_W=14, DIGITS=4, bin=0, start pulse → done after 15 edges; bcd=16'h0000, blank=4'b1110, overflow=0.
2. bin=42 → bcd=16'h0042, blank=4'b1100, overflow=0. Then bin=9999 → bcd=16'h9999, blank=4'b0000, overflow=0.
3. bin=16383 (max) → bcd=16'h6383, overflow=1. Repeat with DIGITS=5 → bcd=20'h16383, overflow=0, blank=5'b00000.
4. Pulse start with bin=1234. Change bin to 777 and pulse start again 5 cycles later → the second start is ignored; the single done gives bcd=16'h1234 and ready returns high.
5. Back-to-back: hold start=1 with bin=1 then bin=2 presented in the DONE cycle → two done pulses 15 cycles apart, giving 16'h0001 then 16'h0002.
6. Assert rst_n=0 at SHIFT cycle 7 of a conversion of 5000 → outputs go to reset values immediately and no done pulse appears. A start after release converts 5000 correctly.
